// File: rtl/instr_seq_ctrl.sv
// Instruction sequencer: fetches a one- or two-byte instruction, decodes it
// and strobes register file, ALU and PC controls cycle by cycle.
module instr_seq_ctrl (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       step_mode,
  input  logic [7:0] instr,
  input  logic       flag_z,
  output logic       mem_rd,
  output logic [1:0] RA,
  output logic       rd,
  output logic       wr,
  output logic [1:0] res_dest,
  output logic [2:0] alu_op,
  output logic       imm_sel,
  output logic [1:0] pc_M,
  output logic [7:0] pc_data,
  output logic [7:0] ir,
  output logic [7:0] operand,
  output logic       busy,
  output logic       halted,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_FETCH2 = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     cur, nxt, after;
  logic [3:0] opcode;
  logic       is_alu;

  assign opcode = ir[7:4];
  assign is_alu = (opcode >= OP_MOV) && (opcode <= OP_OR);
  // Where an instruction goes when it retires: stop after it in step mode.
  assign after  = step_mode ? S_IDLE : S_FETCH;
  assign state  = cur;

  // State register; clr drops straight back to IDLE so no strobe survives it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) cur <= S_IDLE;
    else     cur <= nxt;
  end

  // Latch the opcode byte in FETCH and the second byte in FETCH2.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ir      <= '0;
      operand <= '0;
    end else begin
      if (cur == S_FETCH)  ir      <= instr;
      if (cur == S_FETCH2) operand <= instr;
    end
  end

  // Next-state sequencing.
  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:   nxt = start ? S_FETCH : S_IDLE;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_LDI || opcode == OP_JMP || opcode == OP_JZ) nxt = S_FETCH2;
        else if (opcode == OP_HALT)                                 nxt = S_HALT;
        else if (is_alu)                                            nxt = S_EXEC;
        else                                                        nxt = after; // NOP and illegal
      end
      S_FETCH2: nxt = S_EXEC;
      S_EXEC:   nxt = (is_alu || opcode == OP_LDI) ? S_WB : after;
      S_WB:     nxt = after;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_IDLE;
    endcase
  end

  // Per-state control strobes; anything not driven stays 0.
  always_comb begin
    mem_rd   = 1'b0;
    RA       = 2'b00;
    rd       = 1'b0;
    wr       = 1'b0;
    res_dest = 2'b00;
    alu_op   = 3'd0;
    imm_sel  = 1'b0;
    pc_M     = 2'b00;
    pc_data  = 8'h00;
    busy     = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    case (cur)
      S_FETCH, S_FETCH2: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        pc_M   = 2'b10;
      end
      S_DECODE: begin
        busy    = 1'b1;
        rd      = 1'b1;
        RA      = ir[1:0];
        illegal = (opcode > OP_JZ) && (opcode < OP_HALT);
      end
      S_EXEC: begin
        busy = 1'b1;
        if (is_alu) begin
          alu_op = 3'(opcode - OP_MOV);
          RA     = ir[1:0];
          rd     = 1'b1;
        end
        if (opcode == OP_JMP || (opcode == OP_JZ && flag_z)) begin
          pc_M    = 2'b01;
          pc_data = operand;
        end
      end
      S_WB: begin
        busy     = 1'b1;
        wr       = 1'b1;
        res_dest = ir[3:2];
        imm_sel  = (opcode == OP_LDI);
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // NOP is decoded implicitly as "not anything else"; keep the name visible.
  logic unused_nop;
  assign unused_nop = (opcode == OP_NOP);

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Self-checking bench for instr_seq_ctrl: per-instruction cycle traces are
// predicted from the instruction-set rules and compared cycle by cycle.
module tb_instr_seq_ctrl;

  logic       clk = 1'b0, clr = 1'b1, start = 1'b0, step_mode = 1'b0, flag_z = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       mem_rd, rd, wr, imm_sel, busy, halted, illegal;
  logic [1:0] RA, res_dest, pc_M;
  logic [2:0] alu_op, state;
  logic [7:0] pc_data, ir, operand;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_rd;
    logic [1:0] RA;
    logic       rd;
    logic       wr;
    logic [1:0] res_dest;
    logic [2:0] alu_op;
    logic       imm_sel;
    logic [1:0] pc_M;
    logic [7:0] pc_data;
    logic       busy;
    logic       halted;
    logic       illegal;
  } snap_t;

  snap_t exp_q[$];
  snap_t obs_q[$];

  instr_seq_ctrl dut (
    .clk(clk), .clr(clr), .start(start), .step_mode(step_mode), .instr(instr),
    .flag_z(flag_z), .mem_rd(mem_rd), .RA(RA), .rd(rd), .wr(wr), .res_dest(res_dest),
    .alu_op(alu_op), .imm_sel(imm_sel), .pc_M(pc_M), .pc_data(pc_data), .ir(ir),
    .operand(operand), .busy(busy), .halted(halted), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  function automatic snap_t snap();
    snap_t t;
    t.state = state;   t.mem_rd = mem_rd;     t.RA = RA;          t.rd = rd;
    t.wr = wr;         t.res_dest = res_dest; t.alu_op = alu_op;  t.imm_sel = imm_sel;
    t.pc_M = pc_M;     t.pc_data = pc_data;   t.busy = busy;      t.halted = halted;
    t.illegal = illegal;
    return t;
  endfunction

  // Reference: the cycle-by-cycle trace of one instruction from the ISA rules.
  function automatic void model(input logic [7:0] b, input logic [7:0] o, input logic f);
    logic [3:0] op;
    snap_t t;
    op = b[7:4];
    exp_q.delete();
    t = '0; t.state = 3'd1; t.mem_rd = 1'b1; t.pc_M = 2'b10; t.busy = 1'b1;
    exp_q.push_back(t);
    t = '0; t.state = 3'd2; t.rd = 1'b1; t.RA = b[1:0]; t.busy = 1'b1;
    t.illegal = (op >= 4'd9 && op <= 4'd14);
    exp_q.push_back(t);
    if (op >= 4'd6 && op <= 4'd8) begin
      t = '0; t.state = 3'd3; t.mem_rd = 1'b1; t.pc_M = 2'b10; t.busy = 1'b1;
      exp_q.push_back(t);
    end
    if (op >= 4'd1 && op <= 4'd8) begin
      t = '0; t.state = 3'd4; t.busy = 1'b1;
      if (op <= 4'd5) begin t.alu_op = 3'(op - 4'd1); t.RA = b[1:0]; t.rd = 1'b1; end
      if (op == 4'd7 || (op == 4'd8 && f)) begin t.pc_M = 2'b01; t.pc_data = o; end
      exp_q.push_back(t);
    end
    if (op >= 4'd1 && op <= 4'd6) begin
      t = '0; t.state = 3'd5; t.wr = 1'b1; t.res_dest = b[3:2]; t.busy = 1'b1;
      t.imm_sel = (op == 4'd6);
      exp_q.push_back(t);
    end
  endfunction

  // Stimulus only: from FETCH, play memory for as many cycles as the model expects.
  task automatic exec_instr(input logic [7:0] b, input logic [7:0] o, input logic f, input logic s);
    obs_q.delete();
    for (int k = 0; k < exp_q.size(); k++) begin
      instr = (k == 0) ? b : (k == 2) ? o : 8'($urandom);
      flag_z = f; step_mode = s;
      @(negedge clk);
      obs_q.push_back(snap());
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (snap() !== snap_t'('0) || ir !== 8'h00 || operand !== 8'h00)
      $display("FAIL reset outputs got=%h ir=%h op=%h exp=0", snap(), ir, operand);
    else passed++;
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd0 || busy !== 1'b0) $display("FAIL reset idle got state=%0d busy=%b exp 0/0", state, busy);
    else passed++;
  endtask

  task automatic test_add();
    model(8'h21, 8'h00, 1'b0);
    pulse_start();
    exec_instr(8'h21, 8'h00, 1'b0, 1'b1);
    checks++;
    if (exp_q.size() != 4) $display("FAIL add latency got=%0d exp=4", exp_q.size()); else passed++;
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) $display("FAIL add cyc%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
      else passed++;
    end
    checks++;
    if (ir !== 8'h21 || state !== 3'd0) $display("FAIL add end got ir=%h state=%0d exp 21/0", ir, state);
    else passed++;
  endtask

  task automatic test_ldi();
    model(8'h68, 8'h5A, 1'b0);
    pulse_start();
    exec_instr(8'h68, 8'h5A, 1'b0, 1'b1);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) $display("FAIL ldi cyc%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
      else passed++;
    end
    checks++;
    if (operand !== 8'h5A) $display("FAIL ldi operand got=%h exp=5a", operand); else passed++;
  endtask

  task automatic test_jumps();
    logic [7:0] bs [3];
    logic       fs [3];
    bs[0] = 8'h80; fs[0] = 1'b0;
    bs[1] = 8'h80; fs[1] = 1'b1;
    bs[2] = 8'h70; fs[2] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      model(bs[j], 8'h40, fs[j]);
      pulse_start();
      exec_instr(bs[j], 8'h40, fs[j], 1'b1);
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k] || obs_q[k].wr !== 1'b0)
          $display("FAIL jump%0d cyc%0d got=%h exp=%h", j, k, obs_q[k], exp_q[k]);
        else passed++;
      end
    end
  endtask

  task automatic test_step();
    model(8'h00, 8'h00, 1'b0);
    pulse_start();
    exec_instr(8'h00, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) $display("FAIL step cyc%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
      else passed++;
    end
    checks++;
    if (state !== 3'd0 || busy !== 1'b0) $display("FAIL step idle got state=%0d busy=%b exp 0/0", state, busy);
    else passed++;
    pulse_start();
    checks++;
    if (state !== 3'd1) $display("FAIL step restart got state=%0d exp=1", state); else passed++;
    do_reset();
  endtask

  task automatic test_illegal();
    logic [7:0] b;
    for (int j = 0; j < 4; j++) begin
      b = (j == 0) ? 8'h90 : {4'($urandom_range(9, 14)), 4'($urandom)};
      model(b, 8'h00, 1'b0);
      pulse_start();
      exec_instr(b, 8'h00, 1'b0, 1'b1);
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) $display("FAIL illegal %h cyc%0d got=%h exp=%h", b, k, obs_q[k], exp_q[k]);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] prog [4];
    prog[0] = 8'h36; prog[1] = 8'h00; prog[2] = 8'h6C; prog[3] = 8'h4B;
    pulse_start();
    for (int j = 0; j < 4; j++) begin
      model(prog[j], 8'hC3, 1'b0);
      exec_instr(prog[j], 8'hC3, 1'b0, 1'b0);
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) $display("FAIL b2b%0d cyc%0d got=%h exp=%h", j, k, obs_q[k], exp_q[k]);
        else passed++;
      end
      checks++;
      if (state !== 3'd1) $display("FAIL b2b%0d next got state=%0d exp=1", j, state); else passed++;
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [7:0] b, o;
    logic       f, s, in_fetch;
    in_fetch = 1'b0;
    for (int j = 0; j < 40; j++) begin
      b = {4'($urandom_range(0, 14)), 4'($urandom)};
      o = 8'($urandom); f = 1'($urandom); s = 1'($urandom);
      if (!in_fetch) pulse_start();
      model(b, o, f);
      exec_instr(b, o, f, s);
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) $display("FAIL rand %h cyc%0d got=%h exp=%h", b, k, obs_q[k], exp_q[k]);
        else passed++;
      end
      checks++;
      if (state !== (s ? 3'd0 : 3'd1) || ir !== b)
        $display("FAIL rand %h end got state=%0d ir=%h exp state=%0d", b, state, ir, s ? 0 : 1);
      else passed++;
      if (b[7:4] >= 4'd6 && b[7:4] <= 4'd8) begin
        checks++;
        if (operand !== o) $display("FAIL rand operand got=%h exp=%h", operand, o); else passed++;
      end
      in_fetch = !s;
    end
    do_reset();
  endtask

  task automatic test_halt();
    snap_t h;
    h = '0; h.state = 3'd6; h.halted = 1'b1;
    model(8'hF0, 8'h00, 1'b0);
    pulse_start();
    exec_instr(8'hF0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) $display("FAIL halt cyc%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
      else passed++;
    end
    for (int j = 0; j < 3; j++) begin
      pulse_start();
      @(posedge clk); #1;
      checks++;
      if (snap() !== h) $display("FAIL halt hold%0d got=%h exp=%h", j, snap(), h); else passed++;
    end
    clr = 1'b1; #1;
    checks++;
    if (state !== 3'd0 || halted !== 1'b0) $display("FAIL halt clr got state=%0d halted=%b exp 0/0", state, halted);
    else passed++;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_abort();
    snap_t z;
    z = '0;
    pulse_start();
    instr = 8'h21;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd4) $display("FAIL abort reach exec got state=%0d exp=4", state); else passed++;
    #2 clr = 1'b1;
    #1;
    checks++;
    if (snap() !== z || ir !== 8'h00) $display("FAIL abort async got=%h ir=%h exp=0", snap(), ir); else passed++;
    @(posedge clk); #1;
    checks++;
    if (wr !== 1'b0 || state !== 3'd0) $display("FAIL abort no wb got wr=%b state=%0d exp 0/0", wr, state);
    else passed++;
    clr = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd0 || wr !== 1'b0) $display("FAIL abort resume got state=%0d wr=%b exp 0/0", state, wr);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldi();
    test_jumps();
    test_step();
    test_illegal();
    test_back_to_back();
    test_random();
    test_halt();
    test_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Safety net: the run is bounded even if the DUT stalls somewhere unexpected.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/instr_seq_ctrl.md
INSTR_SEQ_CTRL -- requirements
Module: instr_seq_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on its rising edge.
REQ-002 SHALL have port: clr  input  1  reset, asynchronous and active-high.
REQ-003 SHALL have port: start  input  1  run request, sampled in IDLE only.
REQ-004 SHALL have port: step_mode  input  1  1 = return to IDLE after every instruction.
REQ-005 SHALL have port: instr  input  8  program-memory byte, valid throughout any cycle with mem_rd=1.
REQ-006 SHALL have port: flag_z  input  1  ALU zero flag from datapath.
REQ-007 SHALL have port: mem_rd  output  1  program-memory read strobe.
REQ-008 SHALL have ports: RA  output  2  register read address; rd  output  1  register read enable.
REQ-009 SHALL have ports: wr  output  1  register write enable; res_dest  output  2  write-back register index.
REQ-010 SHALL have ports: alu_op  output  3  ALU function; imm_sel  output  1  1 = write-back source is operand byte.
REQ-011 SHALL have ports: pc_M  output  2  PC mode (00 hold, 01 load pc_data, 10 increment); pc_data  output  8  PC load value.
REQ-012 SHALL have ports: ir  output  8  instruction register; operand  output  8  second-byte register.
REQ-013 SHALL have ports: busy  output  1; halted  output  1; illegal  output  1; state  output  3.

Function
REQ-014 SHALL decode ir[7:4] opcode, ir[3:2] RD, ir[1:0] RS: 0 NOP, 1 MOV, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 LDI RD,#imm, 7 JMP addr, 8 JZ addr, F HALT; 9-E illegal.
REQ-015 SHALL encode states IDLE=0, FETCH=1, DECODE=2, FETCH2=3, EXEC=4, WB=5, HALT=6.
REQ-016 IDLE: all strobes 0, pc_M=00; start=1 -> FETCH.
REQ-017 FETCH: mem_rd=1, pc_M=10; ir <= instr at cycle end; -> DECODE.
REQ-018 DECODE: rd=1, RA=RS; opcodes 6/7/8 -> FETCH2; 0 -> next; F -> HALT; 9-E -> illegal=1 for this one cycle, then next; others -> EXEC.
REQ-019 FETCH2: mem_rd=1, pc_M=10; operand <= instr at cycle end; -> EXEC.
REQ-020 EXEC: alu_op = opcode-1 for MOV..OR (MOV=0 pass-through, ADD=1, SUB=2, AND=3, OR=4), else 0; RA=RS, rd=1 for MOV..OR; JMP: pc_M=01, pc_data=operand, -> next; JZ: same load only if flag_z=1, else pc_M=00, -> next; MOV..OR, LDI -> WB.
REQ-021 WB: wr=1, res_dest=RD, imm_sel=1 for LDI else 0; -> next.
REQ-022 "next" SHALL mean FETCH if step_mode=0, IDLE if step_mode=1, step_mode sampled in the cycle the transition is taken.
REQ-023 HALT: halted=1, all strobes 0, pc_M=00; SHALL remain until clr.
REQ-024 Latency (cycles FETCH-entry to next FETCH-entry): NOP/illegal 2, MOV..OR 4, LDI 5, JMP/JZ 4.
REQ-025 busy SHALL be 1 in every state except IDLE and HALT; start outside IDLE SHALL be ignored.
REQ-026 wr and pc_M=01 SHALL never assert in the same cycle; mem_rd SHALL be 1 only in FETCH/FETCH2.
REQ-027 Unused outputs SHALL be 0 in every state (RA, res_dest, alu_op, pc_data hold 0 when not driven).
REQ-028 PC wrap 0xFF->0x00 is the datapath's concern; sequencer issues 10 unconditionally in FETCH/FETCH2.

Reset
REQ-029 clr=1 SHALL force, without clock, state=IDLE, ir=0, operand=0 and all outputs 0 (halted=0, busy=0).
REQ-030 clr asserted mid-instruction SHALL abort it with no wr or pc_M pulse after assertion; deassertion resumes in IDLE.

Verification
REQ-031 Reset, start=1 one cycle, instr=0x21 (ADD R0,R1) -> FETCH,DECODE,EXEC(alu_op=1),WB(wr=1,res_dest=0); 4 cycles.
REQ-032 instr=0x68 then 0x5A (LDI R2,#0x5A) -> mem_rd in FETCH and FETCH2, operand=0x5A, WB wr=1,res_dest=2,imm_sel=1.
REQ-033 JZ 0x40 with flag_z=0 -> pc_M=00 in EXEC; flag_z=1 -> pc_M=01,pc_data=0x40; wr=0 throughout.
REQ-034 step_mode=1, instr=0x00 -> IDLE after DECODE, busy=0; start again -> FETCH.
REQ-035 instr=0xF0 -> HALT, halted=1; start pulses ignored; clr -> IDLE, halted=0.
REQ-036 instr=0x90 -> illegal=1 one cycle in DECODE, no wr; clr asserted during EXEC of ADD -> no WB pulse, state=0.
